// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared types and constants for the button event decoder.
//   evt_state_t  : press-window FSM states (IDLE / WINDOW / HOLD)
//   menu_state_t : display/menu FSM states (NORMAL / MENU)
//   MODE_BTN_IDX, TRIP_BTN_IDX : default button indices
//   max_int()    : constant helper used to size the window counter
// -----------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WINDOW = 2'd1,
        HOLD   = 2'd2
    } evt_state_t;

    typedef enum logic {
        NORMAL = 1'b0,
        MENU   = 1'b1
    } menu_state_t;

    localparam int MODE_BTN_IDX = 0;
    localparam int TRIP_BTN_IDX = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Single-bit 2-flop synchroniser followed by a counting debouncer. The output
// level only follows the synchronised input after DEBOUNCE_CYC consecutive
// cycles at the new value; any return to the old value restarts the count.
// Ports:
//   Clock  in  system clock
//   Reset  in  synchronous, active-high reset (level returns to released = 1)
//   raw    in  raw active-low button, asynchronous to Clock
//   level  out debounced active-low level
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 64
) (
    input  logic Clock,
    input  logic Reset,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] stable_cnt;

    // NOTE: non-blocking assignments so every flop samples pre-edge values;
    // blocking here would collapse the synchroniser into a single stage.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync_1     <= 1'b1;
            sync_2     <= 1'b1;
            stable_cnt <= '0;
            level      <= 1'b1;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            if (sync_2 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                // This is the DEBOUNCE_CYC-th consecutive differing cycle.
                level      <= sync_2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_event_decoder.sv
// -----------------------------------------------------------------------------
// btn_event_decoder
// Debounces NUM_BTN active-low buttons, classifies each press window as short,
// long or chord, and drives the display mode, trip reset and wheelsize menu.
// Optional build macro: BTN_AUTOREPEAT_EN adds REPEAT_CYC and value_inc
// auto-repeat while the trip button alone is held long in the menu.
// Ports:
//   Clock, Reset   system clock, synchronous active-high reset
//   nBtn           raw active-low buttons
//   mode           current display mode
//   trip_reset     one-cycle trip reset pulse (never in the menu)
//   menu_active    wheelsize menu open
//   menu_digit     digit selected in the menu
//   digit_advance  pulse: move to next digit
//   value_inc      pulse: increment selected digit
//   menu_done      pulse: menu completed normally
//   evt_valid      pulse: classified event available
//   evt_mask       buttons pressed in the window (valid with evt_valid)
//   evt_long       event was a long press (valid with evt_valid)
// -----------------------------------------------------------------------------
module btn_event_decoder
    import btn_pkg::*;
#(
    parameter int NUM_BTN      = 2,
    parameter int MODE_BTN     = MODE_BTN_IDX,
    parameter int TRIP_BTN     = TRIP_BTN_IDX,
    parameter int DEBOUNCE_CYC = 64,
    parameter int WINDOW_CYC   = 5120,
    parameter int LONG_CYC     = 25600,
    parameter int NUM_MODES    = 6,
    parameter int MENU_DIGITS  = 12
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_CYC   = 2560
`endif
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic [NUM_BTN-1:0]             nBtn,
    output logic [$clog2(NUM_MODES)-1:0]   mode,
    output logic                           trip_reset,
    output logic                           menu_active,
    output logic [$clog2(MENU_DIGITS)-1:0] menu_digit,
    output logic                           digit_advance,
    output logic                           value_inc,
    output logic                           menu_done,
    output logic                           evt_valid,
    output logic [NUM_BTN-1:0]             evt_mask,
    output logic                           evt_long
);

    localparam int MODE_W = $clog2(NUM_MODES);
    localparam int DIG_W  = $clog2(MENU_DIGITS);
    localparam int CNT_W  = $clog2(max_int(WINDOW_CYC, LONG_CYC) + 1);

    localparam logic [NUM_BTN-1:0] ONE_HOT0  = {{(NUM_BTN-1){1'b0}}, 1'b1};
    localparam logic [NUM_BTN-1:0] MODE_ONLY = ONE_HOT0 << MODE_BTN;
    localparam logic [NUM_BTN-1:0] TRIP_ONLY = ONE_HOT0 << TRIP_BTN;
    localparam logic [NUM_BTN-1:0] CHORD     = MODE_ONLY | TRIP_ONLY;

    // ---------------- input path ----------------
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] pressed;
    logic [NUM_BTN-1:0] pressed_q;
    logic [NUM_BTN-1:0] press_edge;
    logic               any_held;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
        btn_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_deb (
            .Clock (Clock),
            .Reset (Reset),
            .raw   (nBtn[i]),
            .level (level[i])
        );
    end

    assign pressed    = ~level;
    assign press_edge = pressed & ~pressed_q;
    assign any_held   = |pressed;

    // ---------------- event FSM ----------------
    evt_state_t         evt_state, evt_state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [NUM_BTN-1:0] win_mask, win_mask_nxt;
    logic               emit;
    logic               emit_long;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            evt_state <= IDLE;
            cnt       <= '0;
            win_mask  <= '0;
            pressed_q <= '0;
            evt_valid <= 1'b0;
            evt_mask  <= '0;
            evt_long  <= 1'b0;
        end else begin
            evt_state <= evt_state_nxt;
            cnt       <= cnt_nxt;
            win_mask  <= win_mask_nxt;
            pressed_q <= pressed;
            evt_valid <= emit;
            evt_mask  <= emit ? win_mask : '0;
            evt_long  <= emit_long;
        end
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        evt_state_nxt = evt_state;
        cnt_nxt       = cnt;
        win_mask_nxt  = win_mask;
        unique case (evt_state)
            IDLE: begin
                if (|press_edge) begin
                    evt_state_nxt = WINDOW;
                    cnt_nxt       = CNT_W'(1);
                    win_mask_nxt  = press_edge;
                end
            end
            WINDOW: begin
                cnt_nxt      = cnt + 1'b1;
                win_mask_nxt = win_mask | press_edge;
                if (cnt == CNT_W'(WINDOW_CYC)) begin
                    // Mask is frozen at the window boundary.
                    win_mask_nxt = win_mask;
                    if (!any_held) begin
                        evt_state_nxt = IDLE;
                        cnt_nxt       = '0;
                        win_mask_nxt  = '0;
                    end else begin
                        evt_state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!any_held) begin
                    evt_state_nxt = IDLE;
                    cnt_nxt       = '0;
                    win_mask_nxt  = '0;
                end else if (cnt != CNT_W'(LONG_CYC)) begin
                    cnt_nxt = cnt + 1'b1;  // saturates at LONG_CYC
                end
            end
            default: begin
                evt_state_nxt = IDLE;
                cnt_nxt       = '0;
                win_mask_nxt  = '0;
            end
        endcase
    end

    // Long event is launched on the step to LONG_CYC so evt_valid coincides
    // with cnt == LONG_CYC; a release after that point emits nothing.
    always_comb begin
        emit      = 1'b0;
        emit_long = 1'b0;
        case (evt_state)
            WINDOW: emit = (cnt == CNT_W'(WINDOW_CYC)) && !any_held;
            HOLD: begin
                if (!any_held) begin
                    emit = (cnt != CNT_W'(LONG_CYC));
                end else if (cnt == CNT_W'(LONG_CYC - 1)) begin
                    emit      = 1'b1;
                    emit_long = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ---------------- classification ----------------
    logic ev_short_mode, ev_long_mode, ev_short_trip, ev_chord, ev_repeat;

    assign ev_short_mode = evt_valid && !evt_long && (evt_mask == MODE_ONLY);
    assign ev_long_mode  = evt_valid &&  evt_long && (evt_mask == MODE_ONLY);
    assign ev_short_trip = evt_valid && !evt_long && (evt_mask == TRIP_ONLY);
    assign ev_chord      = evt_valid && (evt_mask == CHORD);

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_W = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;

    logic [RPT_W-1:0] rpt_cnt;
    logic             long_sat;
    logic             rpt_fire;
    logic             rpt_tick;

    // Repeat ticks are registered like evt_valid so all value_inc pulses share
    // one latency; the first pulse comes from the long event itself.
    assign long_sat = (evt_state == HOLD) && any_held && (cnt == CNT_W'(LONG_CYC));
    assign rpt_fire = long_sat && (win_mask == TRIP_ONLY) &&
                      (rpt_cnt == RPT_W'(REPEAT_CYC - 1));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rpt_cnt  <= '0;
            rpt_tick <= 1'b0;
        end else begin
            rpt_tick <= rpt_fire;
            if (!long_sat || rpt_cnt == RPT_W'(REPEAT_CYC - 1)) rpt_cnt <= '0;
            else                                                 rpt_cnt <= rpt_cnt + 1'b1;
        end
    end

    assign ev_repeat = (evt_valid && evt_long && (evt_mask == TRIP_ONLY)) || rpt_tick;
`else
    assign ev_repeat = 1'b0;
`endif

    // ---------------- mode / menu FSM ----------------
    menu_state_t       menu_state, menu_state_nxt;
    logic [MODE_W-1:0] mode_nxt;
    logic [DIG_W-1:0]  digit_nxt;
    logic              last_digit;
    logic              trip_reset_nxt, digit_advance_nxt, value_inc_nxt, menu_done_nxt;

    assign last_digit  = (menu_digit == DIG_W'(MENU_DIGITS - 1));
    assign menu_active = (menu_state == MENU);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            menu_state    <= NORMAL;
            mode          <= '0;
            menu_digit    <= '0;
            trip_reset    <= 1'b0;
            digit_advance <= 1'b0;
            value_inc     <= 1'b0;
            menu_done     <= 1'b0;
        end else begin
            menu_state    <= menu_state_nxt;
            mode          <= mode_nxt;
            menu_digit    <= digit_nxt;
            trip_reset    <= trip_reset_nxt;
            digit_advance <= digit_advance_nxt;
            value_inc     <= value_inc_nxt;
            menu_done     <= menu_done_nxt;
        end
    end

    always_comb begin
        menu_state_nxt = menu_state;
        mode_nxt       = mode;
        digit_nxt      = menu_digit;
        unique case (menu_state)
            NORMAL: begin
                if (ev_short_mode) begin
                    mode_nxt = (mode == MODE_W'(NUM_MODES - 1)) ? '0 : mode + 1'b1;
                end else if (ev_long_mode) begin
                    mode_nxt = '0;
                end else if (ev_chord) begin
                    menu_state_nxt = MENU;
                    digit_nxt      = '0;
                end
            end
            MENU: begin
                if (ev_short_mode) begin
                    if (last_digit) begin
                        menu_state_nxt = NORMAL;
                        digit_nxt      = '0;
                        mode_nxt       = '0;
                    end else begin
                        digit_nxt = menu_digit + 1'b1;
                    end
                end else if (ev_chord) begin
                    menu_state_nxt = NORMAL;
                    digit_nxt      = '0;
                end
            end
            default: menu_state_nxt = NORMAL;
        endcase
    end

    always_comb begin
        trip_reset_nxt    = 1'b0;
        digit_advance_nxt = 1'b0;
        value_inc_nxt     = 1'b0;
        menu_done_nxt     = 1'b0;
        case (menu_state)
            NORMAL: trip_reset_nxt = ev_short_trip;
            MENU: begin
                value_inc_nxt     = ev_short_trip || ev_repeat;
                menu_done_nxt     = ev_short_mode && last_digit;
                digit_advance_nxt = ev_short_mode && !last_digit;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_btn_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_btn_event_decoder
// Directed bench for btn_event_decoder with DEBOUNCE_CYC=4, WINDOW_CYC=16,
// LONG_CYC=64, NUM_MODES=6, MENU_DIGITS=3 (REPEAT_CYC=8 when
// BTN_AUTOREPEAT_EN is defined). Latencies are counted in clock cycles from
// the negedge on which nBtn is driven: 2 sync + 4 debounce cycles put the
// debounced edge at posedge 6, evt_valid follows one cycle after the FSM
// decision and mode-side pulses one cycle after evt_valid.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_btn_event_decoder;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [1:0] nBtn  = 2'b11;

    logic [2:0] mode;
    logic       trip_reset, menu_active;
    logic [1:0] menu_digit;
    logic       digit_advance, value_inc, menu_done;
    logic       evt_valid;
    logic [1:0] evt_mask;
    logic       evt_long;

    always #5 Clock = ~Clock;

    btn_event_decoder #(
        .NUM_BTN      (2),
        .MODE_BTN     (0),
        .TRIP_BTN     (1),
        .DEBOUNCE_CYC (4),
        .WINDOW_CYC   (16),
        .LONG_CYC     (64),
        .NUM_MODES    (6),
        .MENU_DIGITS  (3)
`ifdef BTN_AUTOREPEAT_EN
        ,
        .REPEAT_CYC   (8)
`endif
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .nBtn          (nBtn),
        .mode          (mode),
        .trip_reset    (trip_reset),
        .menu_active   (menu_active),
        .menu_digit    (menu_digit),
        .digit_advance (digit_advance),
        .value_inc     (value_inc),
        .menu_done     (menu_done),
        .evt_valid     (evt_valid),
        .evt_mask      (evt_mask),
        .evt_long      (evt_long)
    );

    // ---------------- pulse monitor ----------------
    int unsigned cyc = 0;
    int unsigned n_evt = 0, n_trip = 0, n_vinc = 0, n_adv = 0, n_done = 0;
    logic [1:0]  last_mask = 2'b00;
    logic        last_long = 1'b0;
    int unsigned vinc_cyc[$];

    always @(negedge Clock) begin
        cyc <= cyc + 1;
        if (evt_valid) begin
            n_evt     <= n_evt + 1;
            last_mask <= evt_mask;
            last_long <= evt_long;
        end
        if (trip_reset)    n_trip <= n_trip + 1;
        if (digit_advance) n_adv  <= n_adv + 1;
        if (menu_done)     n_done <= n_done + 1;
        if (value_inc) begin
            n_vinc <= n_vinc + 1;
            vinc_cyc.push_back(cyc);
        end
    end

    // ---------------- checking ----------------
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic tap(input int b, input int len, input int gap);
        nBtn[b] = 1'b0;
        idle(len);
        nBtn[b] = 1'b1;
        idle(gap);
    endtask

    // Mode first, trip 5 cycles later, both released together.
    task automatic chord();
        nBtn[0] = 1'b0;
        idle(5);
        nBtn[1] = 1'b0;
        idle(25);
        nBtn = 2'b11;
        idle(80);
    endtask

    // Returns the number of negedges until evt_valid is seen, or -1.
    task automatic wait_evt(input int max_cyc, output int lat);
        lat = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge Clock);
            if (evt_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    int          lat;
    int unsigned base_evt, base_trip, base_vinc, base_adv, base_done, t0;

    initial begin
        // ---------------- reset state ----------------
        idle(3);
        check("rst_mode", mode, 0);
        check("rst_menu_active", menu_active, 0);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_pulses", {trip_reset, digit_advance, value_inc, menu_done}, 0);
        Reset = 1'b0;
        idle(10);

        // ---------------- 1: six short mode presses ----------------
        for (int i = 1; i <= 6; i++) begin
            tap(0, 10, 90);
            check($sformatf("t1_mode_%0d", i), mode, i % 6);
        end
        check("t1_evt_count", n_evt, 6);
        check("t1_evt_mask", last_mask, 1);
        check("t1_evt_long", last_long, 0);
        check("t1_no_trip_reset", n_trip, 0);

        // ---------------- 2: glitch filtering ----------------
        base_evt = n_evt;
        nBtn[0] = 1'b0; idle(10);
        nBtn[0] = 1'b1; idle(2);
        nBtn[0] = 1'b0; idle(10);
        nBtn[0] = 1'b1; idle(80);
        check("t2_glitch_one_evt", n_evt - base_evt, 1);
        check("t2_glitch_mask", last_mask, 1);
        check("t2_mode_after_glitch", mode, 1);
        base_evt = n_evt;
        tap(0, 3, 60);
        check("t2_short_pulse_no_evt", n_evt - base_evt, 0);

        // ---------------- 3: trip 30 cycles, then 100 cycles ----------------
        base_trip = n_trip;
        nBtn[1] = 1'b0;
        idle(30);
        nBtn[1] = 1'b1;
        wait_evt(40, lat);
        check("t3_release_latency", lat, 7);
        check("t3_short_mask", evt_mask, 2);
        check("t3_short_long", evt_long, 0);
        @(negedge Clock);
        check("t3_trip_reset_next", trip_reset, 1);
        idle(60);
        check("t3_trip_reset_once", n_trip - base_trip, 1);

        base_evt  = n_evt;
        base_trip = n_trip;
        nBtn[1] = 1'b0;
        wait_evt(100, lat);
        check("t3_long_latency", lat, 70);
        check("t3_long_mask", evt_mask, 2);
        check("t3_long_flag", evt_long, 1);
        idle(30);
        nBtn[1] = 1'b1;
        idle(60);
        check("t3_long_one_evt", n_evt - base_evt, 1);
        check("t3_long_no_trip_reset", n_trip - base_trip, 0);
        check("t3_mode_kept", mode, 1);

        // ---------------- 4: menu walk-through ----------------
        base_vinc = n_vinc; base_adv = n_adv; base_done = n_done; base_trip = n_trip;
        chord();
        check("t4_chord_mask", last_mask, 3);
        check("t4_menu_active", menu_active, 1);
        check("t4_menu_digit0", menu_digit, 0);
        check("t4_mode_unchanged", mode, 1);
        tap(1, 10, 90);
        check("t4_digit_after_inc", menu_digit, 0);
        tap(0, 10, 90);
        check("t4_digit1", menu_digit, 1);
        tap(1, 10, 90);
        tap(0, 10, 90);
        check("t4_digit2", menu_digit, 2);
        tap(0, 10, 90);
        check("t4_value_inc_count", n_vinc - base_vinc, 2);
        check("t4_digit_adv_count", n_adv - base_adv, 2);
        check("t4_menu_done_count", n_done - base_done, 1);
        check("t4_no_trip_in_menu", n_trip - base_trip, 0);
        check("t4_menu_closed", menu_active, 0);
        check("t4_mode_zero", mode, 0);
        check("t4_digit_zero", menu_digit, 0);

        // ---------------- 5: chord abort at digit 1 ----------------
        tap(0, 10, 90);
        tap(0, 10, 90);
        check("t5_mode2", mode, 2);
        base_done = n_done;
        chord();
        check("t5_menu_open", menu_active, 1);
        tap(0, 10, 90);
        check("t5_digit1", menu_digit, 1);
        chord();
        check("t5_menu_aborted", menu_active, 0);
        check("t5_no_done", n_done - base_done, 0);
        check("t5_mode_unchanged", mode, 2);
        check("t5_digit_cleared", menu_digit, 0);

        // ---------------- 6: reset mid-window ----------------
        base_evt = n_evt;
        nBtn[0] = 1'b0;
        idle(10);
        nBtn[0] = 1'b1;
        idle(3);
        Reset = 1'b1;          // sampled on the posedge where cnt would reach 8
        idle(2);
        Reset = 1'b0;
        idle(60);
        check("t6_no_evt_after_reset", n_evt - base_evt, 0);
        check("t6_mode_cleared", mode, 0);
        check("t6_outputs_zero",
              {menu_active, menu_digit, trip_reset, digit_advance, value_inc,
               menu_done, evt_valid, evt_mask, evt_long}, 0);

`ifdef BTN_AUTOREPEAT_EN
        // ---------------- 6b: auto-repeat in menu ----------------
        chord();
        check("t6b_menu_open", menu_active, 1);
        base_evt  = n_evt;
        base_vinc = n_vinc;
        vinc_cyc.delete();
        @(negedge Clock);
        t0 = cyc;
        nBtn[1] = 1'b0;
        idle(90);
        nBtn[1] = 1'b1;
        idle(60);
        check("t6b_repeat_count", n_vinc - base_vinc, 4);
        if (vinc_cyc.size() == 4) begin
            check("t6b_first_offset", vinc_cyc[0] - t0, 71);
            for (int i = 1; i < 4; i++)
                check($sformatf("t6b_gap_%0d", i), vinc_cyc[i] - vinc_cyc[i-1], 8);
        end
        check("t6b_only_long_evt", n_evt - base_evt, 1);
        check("t6b_still_in_menu", menu_active, 1);
        check("t6b_digit_kept", menu_digit, 0);
        chord();
        check("t6b_menu_exit", menu_active, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
